// File: rtl/spawn_sched.sv
// Arbitrated random-cell spawn controller: two requesters, retry on occupied cells.
// Optional SPAWN_SCAN_EN: after retry exhaustion, linearly scan the grid for a free cell.
module spawn_sched #(
  parameter int MAX_TRIES = 8,
  parameter int GRID_MAX  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [3:0] rnd_x,
  input  logic [3:0] rnd_y,
  output logic [3:0] occ_x,
  output logic [3:0] occ_y,
  input  logic       occ_hit,
  output logic       spawn_valid,
  output logic       spawn_id,
  output logic [3:0] spawn_x,
  output logic [3:0] spawn_y,
  output logic       spawn_fail,
  input  logic       spawn_ack,
  output logic       busy
);
  localparam logic [3:0] GMAX  = 4'(GRID_MAX);
  localparam logic [3:0] TMAX  = 4'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, SAMPLE, WAIT, CHECK, DONE} state_t;

  state_t     state;
  logic [3:0] tries;
  logic       last_served;
  logic       req_sel;
`ifdef SPAWN_SCAN_EN
  logic       scan;
`endif

  assign req_sel = spawn_id ? req_1 : req_0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tries       <= '0;
      last_served <= 1'b1;
      occ_x       <= '0;
      occ_y       <= '0;
      spawn_valid <= 1'b0;
      spawn_id    <= 1'b0;
      spawn_x     <= '0;
      spawn_y     <= '0;
      spawn_fail  <= 1'b0;
`ifdef SPAWN_SCAN_EN
      scan        <= 1'b0;
`endif
    end else if (state != IDLE && !req_sel) begin
      // Served requester withdrew: drop everything, keep arbitration history.
      state       <= IDLE;
      spawn_valid <= 1'b0;
      spawn_fail  <= 1'b0;
`ifdef SPAWN_SCAN_EN
      scan        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_0 || req_1) begin
          spawn_id <= (req_0 && req_1) ? ~last_served : req_1;
          tries    <= '0;
          state    <= SAMPLE;
        end
        SAMPLE: if (rnd_x <= GMAX && rnd_y <= GMAX) begin
          occ_x <= rnd_x;
          occ_y <= rnd_y;
          tries <= tries + 4'd1;
          state <= WAIT;
        end
        WAIT: state <= CHECK;
        CHECK: begin
          if (!occ_hit) begin
            spawn_x     <= occ_x;
            spawn_y     <= occ_y;
            spawn_fail  <= 1'b0;
            spawn_valid <= 1'b1;
            state       <= DONE;
`ifdef SPAWN_SCAN_EN
            scan        <= 1'b0;
          end else if (scan) begin
            if (occ_x == GMAX && occ_y == GMAX) begin
              spawn_x     <= occ_x;
              spawn_y     <= occ_y;
              spawn_fail  <= 1'b1;
              spawn_valid <= 1'b1;
              scan        <= 1'b0;
              state       <= DONE;
            end else begin
              // x-major walk: x steps fastest, wraps into the next row.
              if (occ_x == GMAX) begin
                occ_x <= '0;
                occ_y <= occ_y + 4'd1;
              end else begin
                occ_x <= occ_x + 4'd1;
              end
              state <= WAIT;
            end
`endif
          end else if (tries < TMAX) begin
            state <= SAMPLE;
          end else begin
`ifdef SPAWN_SCAN_EN
            scan  <= 1'b1;
            occ_x <= '0;
            occ_y <= '0;
            state <= WAIT;
`else
            spawn_x     <= occ_x;
            spawn_y     <= occ_y;
            spawn_fail  <= 1'b1;
            spawn_valid <= 1'b1;
            state       <= DONE;
`endif
          end
        end
        DONE: if (spawn_ack) begin
          last_served <= spawn_id;
          spawn_valid <= 1'b0;
          spawn_fail  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
